// File: rtl/systolic_setup.sv
// ---------------------------------------------------------------------------
// systolic_setup
//
// Input skew stage between a global operand buffer and the edge of the PE
// array. One LANES-wide word is read from the buffer per cycle and is turned
// into a diagonal wavefront: lane r reaches the array r cycles later than
// lane 0. The same block feeds either the A operand (array rows) or the
// B operand (array columns).
//
// Ports
//   clk_i      in   1                 clock, rising edge
//   rst_ni     in   1                 asynchronous active-low reset
//   ensys_i    in   1                 controller read enable (address valid)
//   bubble_i   in   1                 bubble flag, aligned with ensys_i
//   data_en_i  in   LANES             per-lane enable, aligned with ensys_i
//   data_i     in   LANES*DATA_WIDTH  buffer read data, one cycle after ensys_i
//   data_o     out  LANES*DATA_WIDTH  skewed lane data to the PE array edge
//   valid_o    out  LANES             per-lane valid, aligned with data_o
//   busy_o     out  1                 a valid element is still in the skew pipe
// ---------------------------------------------------------------------------
module systolic_setup #(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ensys_i,
  input  logic                          bubble_i,
  input  logic [LANES-1:0]              data_en_i,
  input  logic [LANES*DATA_WIDTH-1:0]   data_i,
  output logic [LANES*DATA_WIDTH-1:0]   data_o,
  output logic [LANES-1:0]              valid_o,
  output logic                          busy_o
);

  // Controls delayed by one cycle so they line up with the buffer read data.
  logic                  ens_r;
  logic                  bub_r;
  logic [LANES-1:0]      den_r;

  // Per-lane element entering the first stage of its skew register.
  logic [LANES-1:0]      v_in_s;
  logic [DATA_WIDTH-1:0] d_in_s [LANES];

  // Per-lane "a valid bit will be in this lane next cycle" term.
  logic [LANES-1:0]      lane_busy_next_s;
  logic                  busy_r;

  // Alignment stage: absorbs the one-cycle read latency of the global buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ens_r <= 1'b0;
      bub_r <= 1'b0;
      den_r <= {LANES{1'b0}};
    end else begin
      ens_r <= ensys_i;
      bub_r <= bubble_i;
      den_r <= data_en_i;
    end
  end

  // Lane input selection. A bubble keeps the valid bit (so the wavefront
  // timing is preserved) but forces the element to zero, which adds nothing
  // to the downstream accumulators. Disabled lanes carry neither data nor valid.
  always_comb begin
    v_in_s = {LANES{1'b0}};
    for (int r = 0; r < LANES; r++) begin
      v_in_s[r] = ens_r & den_r[r];
      if (ens_r && den_r[r] && !bub_r) begin
        d_in_s[r] = data_i[r*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        d_in_s[r] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // One shift register per lane; lane r is r+1 stages deep and its last
  // stage drives the outputs directly, so data_o/valid_o are flop outputs.
  for (genvar r = 0; r < LANES; r++) begin : g_lane
    logic [r:0]            v_sr;
    logic [DATA_WIDTH-1:0] d_sr [r+1];
    logic                  stage_busy_s;

    // Free-running shift: no stall, zeros enter whenever the lane is idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_sr <= {(r+1){1'b0}};
        for (int k = 0; k <= r; k++) begin
          d_sr[k] <= {DATA_WIDTH{1'b0}};
        end
      end else begin
        v_sr[0] <= v_in_s[r];
        d_sr[0] <= d_in_s[r];
        for (int k = 1; k <= r; k++) begin
          v_sr[k] <= v_sr[k-1];
          d_sr[k] <= d_sr[k-1];
        end
      end
    end

    // Valid bits that will occupy this lane after the next edge: the new
    // entry plus every stage except the last, which shifts out.
    always_comb begin
      stage_busy_s = v_in_s[r];
      for (int k = 0; k < r; k++) begin
        stage_busy_s = stage_busy_s | v_sr[k];
      end
    end

    assign lane_busy_next_s[r]                   = stage_busy_s;
    assign data_o[r*DATA_WIDTH +: DATA_WIDTH]    = d_sr[r];
    assign valid_o[r]                            = v_sr[r];
  end

  // busy is the OR of the alignment enable and every valid bit in the pipe.
  // It is computed from next-state values so the output comes straight from
  // a flop while keeping the same cycle timing as the combinational OR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= ensys_i | (|lane_busy_next_s);
    end
  end

  assign busy_o = busy_r;

endmodule

// File: tb/tb_systolic_setup.sv
module tb_systolic_setup;
  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int MAXC  = 1024;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              ensys_i = 1'b0;
  logic              bubble_i = 1'b0;
  logic [LANES-1:0]  data_en_i = '0;
  logic [LANES*DW-1:0] data_i = '0;
  logic [LANES*DW-1:0] data_o;
  logic [LANES-1:0]  valid_o;
  logic              busy_o;

  systolic_setup #(.LANES(LANES), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ensys_i(ensys_i), .bubble_i(bubble_i),
    .data_en_i(data_en_i), .data_i(data_i),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = -1;

  // Stimulus history, one entry per cycle (value held during that cycle).
  bit               ens_h [MAXC];
  bit               bub_h [MAXC];
  bit               rst_h [MAXC];
  logic [LANES-1:0] den_h [MAXC];
  logic [LANES*DW-1:0] dat_h [MAXC];

  // Drive one cycle of inputs just after the rising edge, record them, and
  // return at the falling edge where outputs are sampled.
  task automatic drive(input bit rst, input bit ens, input bit bub,
                       input logic [LANES-1:0] den, input logic [LANES*DW-1:0] dat);
    @(posedge clk_i);
    #1;
    rst_ni = rst; ensys_i = ens; bubble_i = bub; data_en_i = den; data_i = dat;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    rst_h[cyc] = rst; ens_h[cyc] = ens; bub_h[cyc] = bub;
    den_h[cyc] = den; dat_h[cyc] = dat;
    @(negedge clk_i);
  endtask

  // ---- reference model --------------------------------------------------
  // An element issued at cycle c survives to cycle t only if reset stayed
  // released throughout c..t.
  function automatic bit rst_clean(int c, int t);
    for (int j = c; j <= t; j++) if (!rst_h[j]) return 1'b0;
    return 1'b1;
  endfunction

  // Valid of lane r for the controller cycle c, as seen at cycle t.
  function automatic bit in_valid(int c, int t, int r);
    if (c < 0) return 1'b0;
    if (!rst_clean(c, t)) return 1'b0;
    return ens_h[c] && den_h[c][r];
  endfunction

  // Data of lane r for controller cycle c; buffer data arrives at c+1.
  function automatic logic [DW-1:0] in_data(int c, int t, int r);
    logic [LANES*DW-1:0] w;
    if (!in_valid(c, t, r) || bub_h[c]) return '0;
    w = dat_h[c+1];
    return w[r*DW +: DW];
  endfunction

  // Lane r output at cycle t comes from controller cycle t-2-r.
  function automatic logic [DW-1:0] exp_data(int t, int r);
    return in_data(t - 2 - r, t, r);
  endfunction

  function automatic bit exp_valid(int t, int r);
    return in_valid(t - 2 - r, t, r);
  endfunction

  // Busy: the aligned enable, or any valid element in any stage of any lane.
  function automatic bit exp_busy(int t);
    if (!rst_h[t]) return 1'b0;
    if (t >= 1 && ens_h[t-1] && rst_h[t-1]) return 1'b1;
    for (int r = 0; r < LANES; r++)
      for (int k = 0; k <= r; k++)
        if (in_valid(t - 2 - k, t, r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [LANES*DW-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  // ---- tests ------------------------------------------------------------
  task automatic test_reset();
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 1'b1, 1'b0, 8'hFF, {LANES*DW{1'b1}});
      n_cmp++;
      if (data_o !== 64'h0 || valid_o !== 8'h00 || busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL reset cyc=%0d data=%h valid=%h busy=%b required 0/0/0",
                 cyc, data_o, valid_o, busy_o);
      end
    end
  endtask

  task automatic test_single();
    int c;
    logic [DW-1:0] ed;
    bit eb;
    drive(1'b1, 1'b0, 1'b0, 8'h00, '0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, '0);
    c = cyc + 1;
    for (int j = 0; j < 15; j++) begin
      drive(1'b1, j == 0, 1'b0, 8'hFF, (j == 1) ? 64'h0807060504030201 : 64'h0);
      for (int r = 0; r < LANES; r++) begin
        ed = (cyc == c + 2 + r) ? DW'(r + 1) : '0;
        n_cmp++;
        if (data_o[r*DW +: DW] !== ed || valid_o[r] !== (cyc == c + 2 + r)) begin
          n_err++;
          $display("FAIL single lane%0d cyc=%0d got %h/%b required %h/%b",
                   r, cyc - c, data_o[r*DW +: DW], valid_o[r], ed, cyc == c + 2 + r);
        end
      end
      eb = (cyc >= c + 1) && (cyc < c + 10);
      n_cmp++;
      if (busy_o !== eb) begin
        n_err++;
        $display("FAIL single_busy cyc=%0d got %b required %b", cyc - c, busy_o, eb);
      end
    end
  endtask

  task automatic test_bubble();
    logic [DW-1:0] v;
    for (int j = 0; j < 20; j++) begin
      v = DW'(j - 1);
      drive(1'b1, j < 8, (j >= 4) && (j < 8), 8'hFF, (j >= 1) ? {LANES{v}} : 64'h0);
      for (int r = 0; r < LANES; r++) begin
        n_cmp++;
        if (data_o[r*DW +: DW] !== exp_data(cyc, r) || valid_o[r] !== exp_valid(cyc, r)) begin
          n_err++;
          $display("FAIL bubble lane%0d cyc=%0d got %h/%b required %h/%b", r, cyc,
                   data_o[r*DW +: DW], valid_o[r], exp_data(cyc, r), exp_valid(cyc, r));
        end
      end
      n_cmp++;
      if (busy_o !== exp_busy(cyc)) begin
        n_err++;
        $display("FAIL bubble_busy cyc=%0d got %b required %b", cyc, busy_o, exp_busy(cyc));
      end
    end
  endtask

  task automatic test_partial();
    for (int j = 0; j < 14; j++) begin
      drive(1'b1, j < 4, (j == 1) || (j == 3), 8'h07, {LANES{8'h55}});
      for (int r = 0; r < LANES; r++) begin
        n_cmp++;
        if (data_o[r*DW +: DW] !== exp_data(cyc, r) || valid_o[r] !== exp_valid(cyc, r)
            || (r >= 3 && (valid_o[r] !== 1'b0 || data_o[r*DW +: DW] !== 8'h00))) begin
          n_err++;
          $display("FAIL partial lane%0d cyc=%0d got %h/%b required %h/%b", r, cyc,
                   data_o[r*DW +: DW], valid_o[r], exp_data(cyc, r), exp_valid(cyc, r));
        end
      end
      n_cmp++;
      if (busy_o !== exp_busy(cyc)) begin
        n_err++;
        $display("FAIL partial_busy cyc=%0d got %b required %b", cyc, busy_o, exp_busy(cyc));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] lane7 [$];
    int c;
    c = cyc + 1;
    for (int j = 0; j < 28; j++) begin
      drive(1'b1, j < 16, 1'b0, 8'hFF, (j >= 1 && j <= 16) ? rand_word() : 64'h0);
      if (valid_o[7]) lane7.push_back(data_o[7*DW +: DW]);
      for (int r = 0; r < LANES; r++) begin
        n_cmp++;
        if (data_o[r*DW +: DW] !== exp_data(cyc, r) || valid_o[r] !== exp_valid(cyc, r)) begin
          n_err++;
          $display("FAIL b2b lane%0d cyc=%0d got %h/%b required %h/%b", r, cyc,
                   data_o[r*DW +: DW], valid_o[r], exp_data(cyc, r), exp_valid(cyc, r));
        end
      end
      n_cmp++;
      if (busy_o !== exp_busy(cyc)) begin
        n_err++;
        $display("FAIL b2b_busy cyc=%0d got %b required %b", cyc, busy_o, exp_busy(cyc));
      end
    end
    // Lane 7 must carry exactly 16 elements with A's last followed by B's first.
    n_cmp++;
    if (lane7.size() != 16) begin
      n_err++;
      $display("FAIL b2b_count lane7 got %0d elements required 16", lane7.size());
    end else begin
      n_cmp++;
      if (lane7[7] !== dat_h[c+8][7*DW +: DW] || lane7[8] !== dat_h[c+9][7*DW +: DW]) begin
        n_err++;
        $display("FAIL b2b_seam lane7 got %h,%h required %h,%h", lane7[7], lane7[8],
                 dat_h[c+8][7*DW +: DW], dat_h[c+9][7*DW +: DW]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit rst;
    for (int j = 0; j < 26; j++) begin
      rst = !(j == 4 || j == 5);
      drive(rst, (j < 10) || (j >= 12 && j < 14), 1'b0, 8'hFF, rand_word());
      if (!rst) begin
        n_cmp++;
        if (data_o !== 64'h0 || valid_o !== 8'h00 || busy_o !== 1'b0) begin
          n_err++;
          $display("FAIL midreset_flush cyc=%0d data=%h valid=%h busy=%b required 0/0/0",
                   cyc, data_o, valid_o, busy_o);
        end
      end
      for (int r = 0; r < LANES; r++) begin
        n_cmp++;
        if (data_o[r*DW +: DW] !== exp_data(cyc, r) || valid_o[r] !== exp_valid(cyc, r)) begin
          n_err++;
          $display("FAIL midreset lane%0d cyc=%0d got %h/%b required %h/%b", r, cyc,
                   data_o[r*DW +: DW], valid_o[r], exp_data(cyc, r), exp_valid(cyc, r));
        end
      end
      n_cmp++;
      if (busy_o !== exp_busy(cyc)) begin
        n_err++;
        $display("FAIL midreset_busy cyc=%0d got %b required %b", cyc, busy_o, exp_busy(cyc));
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, LANES'($urandom()), rand_word());
      for (int r = 0; r < LANES; r++) begin
        n_cmp++;
        if (data_o[r*DW +: DW] !== exp_data(cyc, r) || valid_o[r] !== exp_valid(cyc, r)) begin
          n_err++;
          $display("FAIL random lane%0d cyc=%0d got %h/%b required %h/%b", r, cyc,
                   data_o[r*DW +: DW], valid_o[r], exp_data(cyc, r), exp_valid(cyc, r));
        end
      end
      n_cmp++;
      if (busy_o !== exp_busy(cyc)) begin
        n_err++;
        $display("FAIL random_busy cyc=%0d got %b required %b", cyc, busy_o, exp_busy(cyc));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bubble();
    test_partial();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
